// File: rtl/el2_lsu_dccm_stbuf.sv
// DCCM store buffer and read/write port arbiter ahead of the DCCM wrapper.
// Optional: define RV_STBUF_STARVE_EN to force drains after STARVE_LIMIT stalls.
module el2_lsu_dccm_stbuf #(
   parameter int DEPTH        = 4,
   parameter int DCCM_BITS    = 16,
   parameter int FDATA_W      = 39,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 st_valid,
   output logic                 st_ready,
   input  logic [DCCM_BITS-1:0] st_addr,
   input  logic [FDATA_W-1:0]   st_data,
   input  logic                 ld_valid,
   output logic                 ld_ready,
   input  logic [DCCM_BITS-1:0] ld_addr,
   output logic                 ld_rsp_valid,
   output logic [FDATA_W-1:0]   ld_rsp_data,
   output logic                 dccm_wren,
   output logic                 dccm_rden,
   output logic [DCCM_BITS-1:0] dccm_wr_addr_lo,
   output logic [DCCM_BITS-1:0] dccm_wr_addr_hi,
   output logic [DCCM_BITS-1:0] dccm_rd_addr_lo,
   output logic [DCCM_BITS-1:0] dccm_rd_addr_hi,
   output logic [FDATA_W-1:0]   dccm_wr_data_lo,
   output logic [FDATA_W-1:0]   dccm_wr_data_hi,
   input  logic [FDATA_W-1:0]   dccm_rd_data_lo,
   output logic                 stbuf_empty,
   output logic                 stbuf_full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DCCM_BITS-1:0] addr_q [DEPTH];
   logic [FDATA_W-1:0]   data_q [DEPTH];
   logic [DEPTH-1:0]     vld_q;
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [CW-1:0]        count;

   logic enq;
   logic drain;
   logic issue;
   logic hazard;
   logic force_drain;

   assign stbuf_empty = (count == '0);
   assign stbuf_full  = (count == CW'(DEPTH));
   assign st_ready    = ~stbuf_full;
   assign enq         = st_valid & st_ready;

   // Word-address match of the load against every occupied entry.
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i] &&
             addr_q[i][DCCM_BITS-1:2] == ld_addr[DCCM_BITS-1:2])
            hazard = 1'b1;
      end
   end

`ifdef RV_STBUF_STARVE_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   logic [SW-1:0] starve_q;

   // Count occupied cycles without a drain, saturating at the limit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         starve_q <= '0;
      else if (drain)
         starve_q <= '0;
      else if (!stbuf_empty && starve_q != SW'(STARVE_LIMIT))
         starve_q <= starve_q + 1'b1;
   end

   assign force_drain = (starve_q == SW'(STARVE_LIMIT));
`else
   assign force_drain = 1'b0;
`endif

   // Loads win the port unless hazarded or a drain is forced.
   always_comb begin
      issue = ld_valid & ~hazard & ~force_drain & ~rst;
      drain = ~issue & ~stbuf_empty & ~rst;
   end

   assign ld_ready        = issue;
   assign dccm_rden       = issue;
   assign dccm_wren       = drain;
   assign dccm_rd_addr_lo = ld_addr;
   assign dccm_rd_addr_hi = ld_addr;
   assign dccm_wr_addr_lo = addr_q[rd_ptr];
   assign dccm_wr_addr_hi = addr_q[rd_ptr];
   assign dccm_wr_data_lo = data_q[rd_ptr];
   assign dccm_wr_data_hi = data_q[rd_ptr];

   // Entry payload; contents are don't-care until marked valid.
   always_ff @(posedge clk) begin
      if (enq) begin
         addr_q[wr_ptr] <= st_addr;
         data_q[wr_ptr] <= st_data;
      end
   end

   // Pointers, occupancy and per-entry valid bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         vld_q  <= '0;
      end else begin
         if (enq) begin
            wr_ptr         <= wr_ptr + 1'b1;
            vld_q[wr_ptr]  <= 1'b1;
         end
         if (drain) begin
            rd_ptr         <= rd_ptr + 1'b1;
            vld_q[rd_ptr]  <= 1'b0;
         end
         if (enq && !drain)
            count <= count + 1'b1;
         else if (drain && !enq)
            count <= count - 1'b1;
      end
   end

   // Load response strobe trails the read strobe by one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ld_rsp_valid <= 1'b0;
      else
         ld_rsp_valid <= dccm_rden;
   end

   assign ld_rsp_data = ld_rsp_valid ? dccm_rd_data_lo : '0;

endmodule
